// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
//
// Pulls words out of a synchronous FIFO (read data one cycle after rd_en) and
// presents them on a valid/ready stream, grouping beats into bursts of
// BURST_LEN with m_last on the final beat. A 2-entry skid buffer absorbs the
// one-cycle read latency so a full-rate stream survives downstream stalls
// without dropping or duplicating words.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : 1 = drain, 0 = stop issuing reads and flush what is owed
//   fifo_empty      : FIFO empty flag
//   fifo_underflow  : FIFO underflow flag (sets err_underflow, discards data)
//   fifo_data_out   : FIFO read data
//   fifo_rd_en      : FIFO read request (combinational)
//   m_valid/m_ready : downstream handshake
//   m_data, m_last  : downstream beat and end-of-burst marker
//   busy            : controller is not IDLE
//   err_underflow   : sticky underflow flag, cleared only by reset
//   beat_total      : free-running count of delivered beats
// -----------------------------------------------------------------------------
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [15:0]           beat_total
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                         state, state_nxt;
    logic [1:0]                     count;     // occupied skid entries, 0..2
    logic                           inflight;  // read issued last cycle, data arrives now
    logic [1:0][FIFO_WIDTH-1:0]     skid;      // skid[0] is always the oldest word
    logic [7:0]                     beat_cnt;
    logic                           pop;
    logic                           capture;
    logic [2:0]                     occ;       // entries owed after this cycle settles

    assign pop     = m_valid & m_ready;
    // Data belonging to an underflowing cycle is dropped, never buffered.
    assign capture = inflight & ~fifo_underflow;

    // Count what the buffer will hold once this cycle's arrival and departure
    // are both accounted for; a new read only goes out if its data will have
    // a free slot when it lands next cycle. pop implies count>=1, so no wrap.
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == RUN) & ~fifo_empty & (occ < 3'd2);

    assign m_valid = (count != 2'd0);
    assign m_data  = skid[0];
    assign m_last  = (count != 2'd0) & (beat_cnt == LAST_BEAT);
    assign busy    = (state != IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RUN;
            RUN:  if (!enable) state_nxt = STOP;
            STOP: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (!inflight && (count == 2'd0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------- read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en & ~fifo_empty;
        end
    end

    // ---------------------------------------------------------- skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            skid  <= '0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    // Read pacing guarantees count<2 here; guard anyway.
                    if (count != 2'd2) begin
                        skid[count[0]] <= fifo_data_out;
                        count          <= count + 2'd1;
                    end
                end
                2'b01: begin
                    skid[0] <= skid[1];
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever
                    // remains after the head leaves.
                    if (count == 2'd1) begin
                        skid[0] <= fifo_data_out;
                    end else begin
                        skid[0] <= skid[1];
                        skid[1] <= fifo_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ beat accounting
    // beat_cnt survives STOP so an interrupted burst resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= 8'd0;
            beat_total <= 16'd0;
        end else if (pop) begin
            beat_cnt   <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
            beat_total <= beat_total + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (fifo_underflow) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_ctrl
//
// Directed bench: a tiny FIFO model feeds the controller, a negedge monitor
// logs every delivered beat, and the main sequence compares logs and outputs
// against hand-computed values. Inputs change only at posedge+1.
// -----------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_underflow = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
    logic         err_underflow;
    logic [15:0]  beat_total;

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.FIFO_WIDTH(W), .BURST_LEN(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .beat_total     (beat_total)
    );

    // FIFO model: writer owns n_push, reader owns n_pop.
    logic [W-1:0] mem [0:63];
    int           n_push = 0;
    int           n_pop  = 0;

    assign fifo_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[n_pop];
            n_pop         <= n_pop + 1;
        end
    end

    // Beat monitor.
    logic [W-1:0] got_d [$];
    logic         got_l [$];
    int           got_c [$];
    int           cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_c.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w);
        mem[n_push] = W'(w);
        n_push      = n_push + 1;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (got_d.size() < target && k < budget) begin
            step();
            k++;
        end
        chk("pop_timeout", 32'(got_d.size() >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Words first..first+n-1 delivered from log index base; m_last on every
    // 4th beat counted from beat0 since the last reset.
    task automatic chk_seq(input int base, input int first, input int n, input int beat0);
        chk("seq_len", 32'(got_d.size()), 32'(base + n));
        if (got_d.size() >= base + n) begin
            for (int i = 0; i < n; i++) begin
                chk("seq_data", 32'(got_d[base+i]), 32'(first + i));
                chk("seq_last", 32'(got_l[base+i]), 32'(((beat0 + i) % 4) == 3));
            end
        end
    endtask

    initial begin
        // ---- reset held with enable=1 and a non-empty FIFO
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(i);
        repeat (3) begin
            step();
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_total", 32'(beat_total), 32'd0);

        // ---- streaming 1..8, back-to-back beats
        rst_n = 1'b1;
        wait_pops(8, 40);
        chk_seq(0, 1, 8, 0);
        if (got_c.size() >= 8) begin
            for (int i = 1; i < 8; i++) chk("stream_gap", 32'(got_c[i] - got_c[0]), 32'(i));
        end
        step();
        step();
        chk("stream_total", 32'(beat_total), 32'd8);
        chk("stream_drained", 32'(m_valid), 32'd0);
        chk("stream_busy", 32'(busy), 32'd1);

        // ---- backpressure: 5-cycle stall after word 10
        for (int i = 9; i <= 16; i++) push(i);
        wait_pops(10, 20);
        m_ready = 1'b0;
        repeat (5) begin
            step();
            chk("bp_vld", 32'(m_valid), 32'd1);
            chk("bp_data", 32'(m_data), 32'd11);
        end
        chk("bp_ahead", 32'(n_pop - got_d.size()), 32'd2);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        wait_pops(16, 30);
        chk_seq(8, 9, 8, 8);
        step();
        chk("bp_total", 32'(beat_total), 32'd16);

        // ---- stop after beat 2 of a burst, then resume
        for (int i = 17; i <= 24; i++) push(i);
        wait_pops(18, 20);
        enable = 1'b0;
        wait_idle(30);
        chk("stop_no_loss", 32'(n_pop - got_d.size()), 32'd0);
        chk("stop_vld", 32'(m_valid), 32'd0);
        chk("stop_partial", 32'(got_d.size() < 24), 32'd1);
        repeat (3) step();
        chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_pops(24, 40);
        chk_seq(16, 17, 8, 16);
        step();
        chk("stop_total", 32'(beat_total), 32'd24);

        // ---- FIFO runs dry mid-stream, then refills
        push(25);
        push(26);
        wait_pops(26, 20);
        repeat (3) begin
            step();
            chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        chk("empty_vld", 32'(m_valid), 32'd0);
        chk("empty_busy", 32'(busy), 32'd1);
        for (int i = 27; i <= 29; i++) push(i);
        wait_pops(29, 20);
        chk_seq(24, 25, 5, 24);
        step();
        chk("empty_total", 32'(beat_total), 32'd29);

        // ---- underflow with a full buffer, then async reset mid-burst
        m_ready = 1'b0;
        push(30);
        push(31);
        push(32);
        repeat (6) step();
        chk("uf_vld", 32'(m_valid), 32'd1);
        chk("uf_data", 32'(m_data), 32'd30);
        chk("uf_ahead", 32'(n_pop - got_d.size()), 32'd2);
        chk("uf_err_pre", 32'(err_underflow), 32'd0);
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        chk("uf_err_set", 32'(err_underflow), 32'd1);
        repeat (4) step();
        chk("uf_err_hold", 32'(err_underflow), 32'd1);
        push(33);
        push(34);
        push(35);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("arst_vld", 32'(m_valid), 32'd0);
        chk("arst_data", 32'(m_data), 32'd0);
        chk("arst_last", 32'(m_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err_underflow), 32'd0);
        chk("arst_total", 32'(beat_total), 32'd0);
        step();
        m_ready = 1'b1;
        rst_n   = 1'b1;
        // 30 and 31 were discarded by reset; 32 was still in the FIFO.
        wait_pops(33, 30);
        chk_seq(29, 32, 4, 0);
        step();
        chk("post_rst_total", 32'(beat_total), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
